// File: rtl/xgmii_pkg.sv
// Shared XGMII character codes, word constants and types for the 64-bit TX path.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
  } xgmii64_t;

  localparam xgmii64_t IDLE_WORD  = {{8{XGMII_IDLE}}, 8'hFF};
  localparam xgmii64_t ERROR_WORD = {{8{XGMII_ERROR}}, 8'hFF};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DRAIN = 2'd2,
    IPG   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/xgmii_char_detect_64b.sv
// Combinational start/terminate detection on one 64-bit XGMII word.
module xgmii_char_detect_64b
  import xgmii_pkg::*;
(
  input  logic [63:0] data,
  input  logic [7:0]  ctrl,
  output logic        is_start,
  output logic        is_term
);

  logic lane0_start;
  logic lane4_start;

  // Start may sit in lane 0, or in lane 4 behind four idle lanes.
  always_comb begin
    lane0_start = ctrl[0] && (data[7:0] == XGMII_START);
    lane4_start = ctrl[4] && (data[39:32] == XGMII_START) &&
                  (ctrl[3:0] == 4'hF) && (data[31:0] == {4{XGMII_IDLE}});
    is_start    = lane0_start || lane4_start;
    is_term     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      is_term = is_term | (ctrl[i] && (data[8*i +: 8] == XGMII_TERM));
    end
  end

endmodule

// File: rtl/xgmii_tx_arbiter_64b.sv
// Frame-level round-robin arbiter sharing one 64-bit XGMII TX stream
// between two sources, with IPG insertion and underrun/oversize abort.
module xgmii_tx_arbiter_64b
  import xgmii_pkg::*;
#(
  parameter int MIN_IPG_WORDS   = 1,
  parameter int MAX_FRAME_WORDS = 1200,
  parameter int CNT_WIDTH       = 11
) (
  input  logic        clk_tx,
  input  logic        rst_tx,
  input  logic [63:0] s0_data,
  input  logic [7:0]  s0_ctrl,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [63:0] s1_data,
  input  logic [7:0]  s1_ctrl,
  input  logic        s1_valid,
  output logic        s1_ready,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [1:0]  grant,
  output logic        err_underrun,
  output logic        err_oversize
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_FRAME_WORDS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [3:0]           IPG_LOAD = 4'(MIN_IPG_WORDS - 1);

  arb_state_t           state;
  xgmii64_t             tx;
  xgmii64_t             word0;
  xgmii64_t             word1;
  xgmii64_t             own_word;
  logic                 is_start0;
  logic                 is_start1;
  logic                 is_term0;
  logic                 is_term1;
  logic                 st0;
  logic                 st1;
  logic                 pick0;
  logic                 pick1;
  logic                 own_valid;
  logic                 own_term;
  logic                 last_grant;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [3:0]           ipg_left;

  assign word0     = {s0_data, s0_ctrl};
  assign word1     = {s1_data, s1_ctrl};
  assign xgmii_txd = tx.data;
  assign xgmii_txc = tx.ctrl;

  xgmii_char_detect_64b u_det0 (
    .data     (s0_data),
    .ctrl     (s0_ctrl),
    .is_start (is_start0),
    .is_term  (is_term0)
  );

  xgmii_char_detect_64b u_det1 (
    .data     (s1_data),
    .ctrl     (s1_ctrl),
    .is_start (is_start1),
    .is_term  (is_term1)
  );

  // Tie-break favours the source that was not granted last.
  always_comb begin
    st0       = s0_valid && is_start0;
    st1       = s1_valid && is_start1;
    pick1     = st1 && (!st0 || !last_grant);
    pick0     = st0 && !pick1;
    own_word  = grant[1] ? word1 : word0;
    own_valid = grant[1] ? s1_valid : s0_valid;
    own_term  = grant[1] ? is_term1 : is_term0;
    cnt_inc   = (cnt == MAX_CNT) ? cnt : cnt + CNT_ONE;
  end

  // In IDLE a source only holds back its own start word when it loses a tie.
  always_comb begin
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    if (rst_tx) begin
      s0_ready = 1'b0;
      s1_ready = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s0_ready = !(is_start0 && st1 && !last_grant);
          s1_ready = !(is_start1 && st0 && last_grant);
        end
        FRAME, DRAIN: begin
          s0_ready = grant[0];
          s1_ready = grant[1];
        end
        default: begin
          s0_ready = 1'b0;
          s1_ready = 1'b0;
        end
      endcase
    end
  end

  // Arbitration FSM with registered XGMII output, grant and error pulses.
  always_ff @(posedge clk_tx) begin
    if (rst_tx) begin
      state        <= IDLE;
      tx           <= IDLE_WORD;
      grant        <= 2'b00;
      last_grant   <= 1'b1;
      cnt          <= '0;
      ipg_left     <= 4'd0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
      case (state)
        IDLE: begin
          tx <= IDLE_WORD;
          if (pick0 || pick1) begin
            tx         <= pick1 ? word1 : word0;
            grant      <= pick1 ? 2'b10 : 2'b01;
            last_grant <= pick1;
            cnt        <= CNT_ONE;
            if (pick1 ? is_term1 : is_term0) begin
              state    <= IPG;
              ipg_left <= IPG_LOAD;
            end else begin
              state <= FRAME;
            end
          end
        end
        FRAME: begin
          if (!own_valid) begin
            tx           <= ERROR_WORD;
            err_underrun <= 1'b1;
            state        <= DRAIN;
          end else if (!own_term && (cnt_inc == MAX_CNT)) begin
            tx           <= ERROR_WORD;
            err_oversize <= 1'b1;
            cnt          <= cnt_inc;
            state        <= DRAIN;
          end else begin
            tx  <= own_word;
            cnt <= cnt_inc;
            if (own_term) begin
              state    <= IPG;
              ipg_left <= IPG_LOAD;
            end
          end
        end
        DRAIN: begin
          tx <= IDLE_WORD;
          if (own_valid && own_term) begin
            state    <= IPG;
            ipg_left <= IPG_LOAD;
          end
        end
        IPG: begin
          tx    <= IDLE_WORD;
          grant <= 2'b00;
          if (ipg_left == 4'd0) begin
            state <= IDLE;
          end else begin
            ipg_left <= ipg_left - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_WORD;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xgmii_tx_arbiter_64b.sv
// Directed bench: queued source frames, per-cycle output log, hand-derived expectations.
module tb_xgmii_tx_arbiter_64b;
  import xgmii_pkg::*;

  typedef struct { logic v; xgmii64_t w; } item_t;
  typedef struct { xgmii64_t o; logic [1:0] g; logic eu; logic eo; logic r0; logic r1; } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s0_data, s1_data;
  logic [7:0]  s0_ctrl, s1_ctrl;
  logic        s0_valid, s1_valid;
  logic        r0_a, r1_a, eu_a, eo_a, r0_b, r1_b, eu_b, eo_b;
  logic [63:0] txd_a, txd_b;
  logic [7:0]  txc_a, txc_b;
  logic [1:0]  grant_a, grant_b;

  item_t q0[$];
  item_t q1[$];
  obs_t  lg[$];
  logic  use_b = 1'b0;
  int    n_chk = 0;
  int    n_bad = 0;

  localparam xgmii64_t SL4 = {64'hFDBBAAFB_07070707, 8'h9F};

  xgmii_tx_arbiter_64b #(.MIN_IPG_WORDS(1), .MAX_FRAME_WORDS(16), .CNT_WIDTH(11)) dut_a (
    .clk_tx(clk), .rst_tx(rst),
    .s0_data(s0_data), .s0_ctrl(s0_ctrl), .s0_valid(s0_valid), .s0_ready(r0_a),
    .s1_data(s1_data), .s1_ctrl(s1_ctrl), .s1_valid(s1_valid), .s1_ready(r1_a),
    .xgmii_txd(txd_a), .xgmii_txc(txc_a), .grant(grant_a),
    .err_underrun(eu_a), .err_oversize(eo_a)
  );

  xgmii_tx_arbiter_64b #(.MIN_IPG_WORDS(3), .MAX_FRAME_WORDS(1200), .CNT_WIDTH(11)) dut_b (
    .clk_tx(clk), .rst_tx(rst),
    .s0_data(s0_data), .s0_ctrl(s0_ctrl), .s0_valid(s0_valid), .s0_ready(r0_b),
    .s1_data(s1_data), .s1_ctrl(s1_ctrl), .s1_valid(s1_valid), .s1_ready(r1_b),
    .xgmii_txd(txd_b), .xgmii_txc(txc_b), .grant(grant_b),
    .err_underrun(eu_b), .err_oversize(eo_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Word k of an n-word frame: start in lane 0, data words, terminate in lane 3.
  function automatic xgmii64_t fw(input int src, input int tag, input int n, input int k);
    xgmii64_t w;
    if (k == 0) w = {40'hD555555555, 4'(src + 1), 4'(tag), 16'h55FB, 8'h01};
    else if (k == n - 1) w = {32'h07070707, 8'hFD, 4'(tag), 4'(src + 1), 8'h33, 8'h22, 8'hF8};
    else w = {4'(src + 1), 4'(tag), 48'h0, 8'(k), 8'h00};
    return w;
  endfunction

  task automatic push_word(input int src, input logic v, input xgmii64_t w);
    item_t it;
    it.v = v;
    it.w = w;
    if (src == 0) q0.push_back(it);
    else q1.push_back(it);
  endtask

  task automatic push_frame(input int src, input int tag, input int n);
    for (int k = 0; k < n; k++) push_word(src, 1'b1, fw(src, tag, n, k));
  endtask

  task automatic drive_heads();
    if (q0.size() > 0) begin
      s0_valid = q0[0].v; s0_data = q0[0].w.data; s0_ctrl = q0[0].w.ctrl;
    end else begin
      s0_valid = 1'b0; s0_data = 64'h0; s0_ctrl = 8'h00;
    end
    if (q1.size() > 0) begin
      s1_valid = q1[0].v; s1_data = q1[0].w.data; s1_ctrl = q1[0].w.ctrl;
    end else begin
      s1_valid = 1'b0; s1_data = 64'h0; s1_ctrl = 8'h00;
    end
  endtask

  task automatic run(input int n);
    obs_t ob;
    for (int c = 0; c < n; c++) begin
      drive_heads();
      #1;
      ob.r0 = use_b ? r0_b : r0_a;
      ob.r1 = use_b ? r1_b : r1_a;
      @(posedge clk);
      #1;
      if (q0.size() > 0 && (!q0[0].v || ob.r0)) void'(q0.pop_front());
      if (q1.size() > 0 && (!q1[0].v || ob.r1)) void'(q1.pop_front());
      ob.o.data = use_b ? txd_b : txd_a;
      ob.o.ctrl = use_b ? txc_b : txc_a;
      ob.g      = use_b ? grant_b : grant_a;
      ob.eu     = use_b ? eu_b : eu_a;
      ob.eo     = use_b ? eo_b : eo_a;
      lg.push_back(ob);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    drive_heads();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    lg.delete();
  endtask

  task automatic chk_out(input string tag, input int k, input xgmii64_t exp, input logic [1:0] g,
                         input logic eu = 1'b0, input logic eo = 1'b0);
    check($sformatf("%s[%0d]", tag, k), {lg[k].o, lg[k].g, lg[k].eu, lg[k].eo}, {exp, g, eu, eo});
  endtask

  function automatic int n_pulse(input bit oversize);
    int c = 0;
    foreach (lg[i]) c += oversize ? int'(lg[i].eo) : int'(lg[i].eu);
    return c;
  endfunction

  initial begin
    rst = 1'b1;
    drive_heads();
    @(posedge clk); #1;
    check("rst_ready_a", {r0_a, r1_a}, 2'b00);
    check("rst_ready_b", {r0_b, r1_b}, 2'b00);
    check("rst_out_a", {txd_a, txc_a, grant_a, eu_a, eo_a}, {IDLE_WORD, 2'b00, 1'b0, 1'b0});
    check("rst_out_b", {txd_b, txc_b, grant_b, eu_b, eo_b}, {IDLE_WORD, 2'b00, 1'b0, 1'b0});

    // Single 8-word frame from source 0.
    do_reset();
    push_frame(0, 1, 8);
    run(11);
    for (int k = 0; k < 8; k++) chk_out("t1_word", k, fw(0, 1, 8, k), 2'b01);
    for (int k = 8; k < 11; k++) chk_out("t1_idle", k, IDLE_WORD, 2'b00);
    for (int k = 1; k < 8; k++) check($sformatf("t1_r1[%0d]", k), lg[k].r1, 1'b0);
    check("t1_ipg_r0", lg[8].r0, 1'b0);

    // Ties: source 0 first after reset, then alternation by last grant.
    do_reset();
    push_frame(0, 2, 4); push_frame(0, 3, 2);
    push_frame(1, 4, 3); push_frame(1, 5, 2);
    run(15);
    for (int k = 0; k < 4; k++) chk_out("t2_s0a", k, fw(0, 2, 4, k), 2'b01);
    chk_out("t2_ipg", 4, IDLE_WORD, 2'b00);
    for (int k = 5; k < 8; k++) chk_out("t2_s1a", k, fw(1, 4, 3, k - 5), 2'b10);
    chk_out("t2_ipg", 8, IDLE_WORD, 2'b00);
    for (int k = 9; k < 11; k++) chk_out("t2_s0b", k, fw(0, 3, 2, k - 9), 2'b01);
    chk_out("t2_ipg", 11, IDLE_WORD, 2'b00);
    for (int k = 12; k < 14; k++) chk_out("t2_s1b", k, fw(1, 5, 2, k - 12), 2'b10);
    chk_out("t2_ipg", 14, IDLE_WORD, 2'b00);
    check("t2_loser1_held", lg[0].r1, 1'b0);
    check("t2_loser0_held", lg[5].r0, 1'b0);

    // Source 1 underrun after word 3 of 10.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k == 3) push_word(1, 1'b0, IDLE_WORD);
      push_word(1, 1'b1, fw(1, 6, 10, k));
    end
    run(13);
    for (int k = 0; k < 3; k++) chk_out("t3_word", k, fw(1, 6, 10, k), 2'b10);
    chk_out("t3_err", 3, ERROR_WORD, 2'b10, 1'b1, 1'b0);
    for (int k = 4; k < 11; k++) chk_out("t3_drain", k, IDLE_WORD, 2'b10);
    for (int k = 11; k < 13; k++) chk_out("t3_ipg", k, IDLE_WORD, 2'b00);
    check("t3_eu_cnt", 80'(n_pulse(1'b0)), 80'd1);

    // Watchdog at 16 words: 20-word frame aborted, 16-word frame clean.
    do_reset();
    push_frame(0, 7, 20); push_frame(0, 8, 16);
    run(39);
    for (int k = 0; k < 15; k++) chk_out("t4_word", k, fw(0, 7, 20, k), 2'b01);
    chk_out("t4_err", 15, ERROR_WORD, 2'b01, 1'b0, 1'b1);
    for (int k = 16; k < 20; k++) chk_out("t4_drain", k, IDLE_WORD, 2'b01);
    chk_out("t4_ipg", 20, IDLE_WORD, 2'b00);
    for (int k = 21; k < 37; k++) chk_out("t4_w16", k, fw(0, 8, 16, k - 21), 2'b01);
    chk_out("t4_ipg2", 37, IDLE_WORD, 2'b00);
    check("t4_eo_cnt", 80'(n_pulse(1'b1)), 80'd1);

    // Lane-4 start with terminate in the same word.
    do_reset();
    push_word(0, 1'b1, SL4);
    push_frame(0, 9, 2);
    run(5);
    chk_out("t5_one", 0, SL4, 2'b01);
    chk_out("t5_ipg", 1, IDLE_WORD, 2'b00);
    chk_out("t5_next", 2, fw(0, 9, 2, 0), 2'b01);
    chk_out("t5_next", 3, fw(0, 9, 2, 1), 2'b01);
    chk_out("t5_ipg2", 4, IDLE_WORD, 2'b00);

    // Mid-frame reset on the MIN_IPG_WORDS=3 instance.
    use_b = 1'b1;
    do_reset();
    push_frame(0, 10, 10);
    run(4);
    for (int k = 0; k < 4; k++) chk_out("t6_pre", k, fw(0, 10, 10, k), 2'b01);
    drive_heads();
    rst = 1'b1;
    #1;
    check("t6_rst_ready", {r0_b, r1_b}, 2'b00);
    @(posedge clk); #1;
    check("t6_rst_out", {txd_b, txc_b, grant_b, eu_b, eo_b}, {IDLE_WORD, 2'b00, 1'b0, 1'b0});
    rst = 1'b0;
    q0.delete();
    lg.delete();
    push_frame(0, 11, 3); push_frame(1, 12, 2);
    run(9);
    for (int k = 0; k < 3; k++) chk_out("t6_new", k, fw(0, 11, 3, k), 2'b01);
    for (int k = 3; k < 6; k++) chk_out("t6_ipg3", k, IDLE_WORD, 2'b00);
    for (int k = 6; k < 8; k++) chk_out("t6_s1", k, fw(1, 12, 2, k - 6), 2'b10);
    chk_out("t6_ipg", 8, IDLE_WORD, 2'b00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
